// File: rtl/bench_out_sequencer.sv
// Output sequencer: routes one of N_CH channels to a registered output, blanking on every switch.
// Define BENCH_OUT_AUTO_SCAN_EN to build the scan pointer and dwell timer driven by scan_en.
module bench_out_sequencer #(
  parameter int N_CH      = 8,
  parameter int OUT_W     = 8,
  parameter int BLANK_CYC = 2,
  parameter int DWELL     = 16,
  localparam int SEL_W    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*OUT_W-1:0] ch_data,
  input  logic                  freeze,
  input  logic                  scan_en,
  output logic [OUT_W-1:0]      out,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      active_ch
);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_LIVE  = 2'd1,
    ST_NULL  = 2'd2
  } state_t;

  localparam logic [3:0]     BLANK_LOAD = 4'(BLANK_CYC);
  localparam logic [SEL_W:0] NCH_EXT    = (SEL_W+1)'(N_CH);

  state_t           state_reg, state_next;
  logic [3:0]       count_reg, count_next;
  logic [SEL_W-1:0] pending_reg, pending_next;
  logic [SEL_W-1:0] active_reg, active_next;
  logic [OUT_W-1:0] out_reg, out_next;
  logic             valid_reg, valid_next;

  logic [SEL_W-1:0] target;
  logic             target_legal;
  logic [OUT_W-1:0] chan_word [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign chan_word[gi] = ch_data[gi*OUT_W +: OUT_W];
    end
  endgenerate

  // The widened compare catches out-of-range selects when N_CH is not a power of two.
  assign target_legal = ({1'b0, target} < NCH_EXT);

`ifdef BENCH_OUT_AUTO_SCAN_EN
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH-1);
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL-1);

  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [7:0]       dwell_reg, dwell_next;

  assign target = scan_en ? ptr_reg : sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg   <= '0;
      dwell_reg <= 8'd0;
    end else begin
      ptr_reg   <= ptr_next;
      dwell_reg <= dwell_next;
    end
  end

  // Dwell only counts settled LIVE cycles; freeze stalls it, anything else clears it.
  always_comb begin
    ptr_next   = ptr_reg;
    dwell_next = 8'd0;
    if (scan_en && state_reg == ST_LIVE) begin
      if (freeze) begin
        dwell_next = dwell_reg;
      end else if (target_legal && target == active_reg) begin
        if (dwell_reg == DWELL_LAST) begin
          ptr_next = (ptr_reg == LAST_CH) ? '0 : ptr_reg + SEL_W'(1);
        end else begin
          dwell_next = dwell_reg + 8'd1;
        end
      end
    end
  end
`else
  localparam int DWELL_UNUSED = DWELL;
  logic scan_unused;
  assign scan_unused = scan_en;
  assign target      = sel;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_BLANK;
      count_reg   <= BLANK_LOAD;
      pending_reg <= '0;
      active_reg  <= '0;
      out_reg     <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      pending_reg <= pending_next;
      active_reg  <= active_next;
      out_reg     <= out_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pending_next = pending_reg;
    active_next  = active_reg;
    out_next     = out_reg;
    valid_next   = valid_reg;
    case (state_reg)
      ST_LIVE: begin
        // Freeze holds everything; requests are re-evaluated once it drops.
        if (!freeze) begin
          if (!target_legal) begin
            state_next = ST_NULL;
            out_next   = '0;
            valid_next = 1'b0;
          end else if (target != active_reg) begin
            state_next   = ST_BLANK;
            count_next   = BLANK_LOAD;
            pending_next = target;
            out_next     = '0;
            valid_next   = 1'b0;
          end else begin
            out_next   = chan_word[active_reg];
            valid_next = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        out_next   = '0;
        valid_next = 1'b0;
        if (!target_legal) begin
          state_next = ST_NULL;
        end else if (target != pending_reg) begin
          pending_next = target;
          count_next   = BLANK_LOAD;
        end else if (count_reg == 4'd1) begin
          state_next  = ST_LIVE;
          count_next  = 4'd0;
          active_next = pending_reg;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      ST_NULL: begin
        out_next   = '0;
        valid_next = 1'b0;
        if (target_legal) begin
          state_next   = ST_BLANK;
          count_next   = BLANK_LOAD;
          pending_next = target;
        end
      end
      default: begin
        state_next = ST_BLANK;
        count_next = BLANK_LOAD;
        out_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  assign out       = out_reg;
  assign out_valid = valid_reg;
  assign active_ch = active_reg;

endmodule

// File: tb/tb_bench_out_sequencer.sv
// Randomised and directed bench for bench_out_sequencer against a cycle-level behavioural model.
// Runs an 8-channel and a 6-channel instance side by side; scan checks need BENCH_OUT_AUTO_SCAN_EN.
module tb_bench_out_sequencer;

  localparam int BLANK = 2;
  localparam int DW    = 4;
`ifdef BENCH_OUT_AUTO_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  localparam int M_BLANK = 0;
  localparam int M_LIVE  = 1;
  localparam int M_NULL  = 2;

  typedef struct {
    int mode;
    int left;
    int pending;
    int active;
    int out;
    int valid;
    int ptr;
    int dwell;
  } mdl_t;

  logic        clk;
  logic        reset;
  logic [2:0]  sel8, sel6;
  logic [63:0] data8;
  logic [47:0] data6;
  logic        freeze, scan_en;
  logic [7:0]  out8, out6;
  logic        out_valid8, out_valid6;
  logic [2:0]  active8, active6;

  int n_cmp  = 0;
  int n_fail = 0;
  mdl_t m8, m6;

  bench_out_sequencer #(.N_CH(8), .OUT_W(8), .BLANK_CYC(BLANK), .DWELL(DW)) dut8 (
    .clk(clk), .reset(reset), .sel(sel8), .ch_data(data8), .freeze(freeze),
    .scan_en(scan_en), .out(out8), .out_valid(out_valid8), .active_ch(active8)
  );

  bench_out_sequencer #(.N_CH(6), .OUT_W(8), .BLANK_CYC(BLANK), .DWELL(DW)) dut6 (
    .clk(clk), .reset(reset), .sel(sel6), .ch_data(data6), .freeze(freeze),
    .scan_en(scan_en), .out(out6), .out_valid(out_valid6), .active_ch(active6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = M_BLANK; r.left = BLANK; r.pending = 0; r.active = 0;
    r.out = 0; r.valid = 0; r.ptr = 0; r.dwell = 0;
    return r;
  endfunction

  // One clock edge of the sequencer as described by its rules.
  function automatic mdl_t step(mdl_t m, int n_ch, int sel_v, logic [63:0] data, bit frz, bit scn);
    mdl_t r;
    bit scanning;
    int tgt;
    bit ok;
    r = m;
    scanning = SCAN_ON && scn;
    tgt = scanning ? m.ptr : sel_v;
    ok = (tgt < n_ch);
    r.dwell = 0;
    if (m.mode == M_LIVE) begin
      if (frz) begin
        if (scanning) r.dwell = m.dwell;
      end else if (!ok) begin
        r.mode = M_NULL; r.out = 0; r.valid = 0;
      end else if (tgt != m.active) begin
        r.mode = M_BLANK; r.left = BLANK; r.pending = tgt; r.out = 0; r.valid = 0;
      end else begin
        r.out = int'((data >> (m.active * 8)) & 64'hFF);
        r.valid = 1;
        if (scanning) begin
          if (m.dwell + 1 == DW) r.ptr = (m.ptr + 1) % n_ch;
          else r.dwell = m.dwell + 1;
        end
      end
    end else begin
      r.out = 0; r.valid = 0;
      if (!ok) r.mode = M_NULL;
      else if (m.mode == M_NULL) begin
        r.mode = M_BLANK; r.left = BLANK; r.pending = tgt;
      end else if (tgt != m.pending) begin
        r.left = BLANK; r.pending = tgt;
      end else if (m.left == 1) begin
        r.mode = M_LIVE; r.left = 0; r.active = m.pending;
      end else begin
        r.left = m.left - 1;
      end
    end
    return r;
  endfunction

  task automatic compare_all();
    chk("out8",    int'(out8),       m8.out);
    chk("valid8",  int'(out_valid8), m8.valid);
    chk("active8", int'(active8),    m8.active);
    chk("out6",    int'(out6),       m6.out);
    chk("valid6",  int'(out_valid6), m6.valid);
    chk("active6", int'(active6),    m6.active);
  endtask

  task automatic tick();
    m8 = step(m8, 8, int'(sel8), data8, freeze, scan_en);
    m6 = step(m6, 6, int'(sel6), {16'h0, data6}, freeze, scan_en);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Reset is raised between edges so the outputs must clear without a clock.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    m8 = mdl_reset();
    m6 = mdl_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    int prev;
    int run;
    int steps;
    reset   = 1'b1;
    sel8    = 3'd0;
    sel6    = 3'd0;
    freeze  = 1'b0;
    scan_en = 1'b0;
    data8   = {$urandom, $urandom};
    data8[7:0]   = 8'hA5;
    data8[31:24] = 8'h3C;
    data6   = data8[47:0];

    // Release from reset onto channel 0
    do_reset();
    chk("rst_out", int'(out8), 0);
    chk("rst_active", int'(active8), 0);
    tick();
    tick();
    chk("rel_e2_valid", int'(out_valid8), 0);
    tick();
    chk("rel_e3_out", int'(out8), 'hA5);
    chk("rel_e3_valid", int'(out_valid8), 1);

    // 0 -> 3 switch
    sel8 = 3'd3; sel6 = 3'd3;
    tick(); tick(); tick();
    chk("sw3_blank_valid", int'(out_valid8), 0);
    chk("sw3_active", int'(active8), 3);
    tick();
    chk("sw3_out", int'(out8), 'h3C);

    // 3 -> 5 -> 6 restart
    sel8 = 3'd5; sel6 = 3'd5;
    tick();
    sel8 = 3'd6; sel6 = 3'd1;
    tick(); tick(); tick();
    chk("rst6_blank_valid", int'(out_valid8), 0);
    tick();
    chk("rst6_valid", int'(out_valid8), 1);
    chk("rst6_active", int'(active8), 6);
    chk("rst6_out", int'(out8), int'(data8[55:48]));

    // Freeze defers a 6 -> 1 request for 10 cycles
    freeze = 1'b1; sel8 = 3'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("frz_hold_out", int'(out8), int'(data8[55:48]));
    end
    freeze = 1'b0;
    tick();
    chk("frz_release_valid", int'(out_valid8), 0);
    tick(); tick(); tick();
    chk("frz_sw1_out", int'(out8), int'(data8[15:8]));
    chk("frz_sw1_active", int'(active8), 1);

    // Illegal select on the 6-channel instance
    sel6 = 3'd7;
    tick();
    chk("null_valid", int'(out_valid6), 0);
    chk("null_active", int'(active6), 1);
    sel6 = 3'd2;
    tick(); tick(); tick(); tick();
    chk("null_exit_out", int'(out6), int'(data6[23:16]));
    chk("null_exit_active", int'(active6), 2);

`ifdef BENCH_OUT_AUTO_SCAN_EN
    // Auto-scan walks every channel and wraps
    do_reset();
    scan_en = 1'b1;
    prev = 0; run = 0; steps = 0;
    for (int i = 0; i < 75; i++) begin
      tick();
      if (out_valid8) run++;
      else if (run != 0) begin
        chk("scan_dwell", run, DW);
        run = 0;
      end
      if (int'(active8) != prev) begin
        chk("scan_step", int'(active8), (prev + 1) % 8);
        prev = int'(active8);
        steps++;
      end
    end
    chk("scan_wrap_seen", int'(steps >= 8), 1);
    scan_en = 1'b0;
`endif

    // Random traffic, including mid-blank and mid-freeze resets
    for (int i = 0; i < 600; i++) begin
      data8 = {$urandom, $urandom};
      data6 = data8[47:0];
      if ($urandom_range(0, 2) == 0) sel8 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) sel6 = 3'($urandom_range(0, 7));
      freeze = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) scan_en = ~scan_en;
      if ($urandom_range(0, 79) == 0) do_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
